// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver: FSM states, error codes and
// header bit positions derived from the UART word width.
package uart_pkt_pkg;

  // StCheck is only entered when UART_PKT_CHECKSUM_EN is defined.
  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCheck,
    StHold
  } pkt_state_e;

  localparam logic [2:0] ERR_HDR     = 3'd0;
  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_CSUM    = 3'd4;

  function automatic int unsigned hdr_rw_bit(input int unsigned word_bits);
    return word_bits - 1;
  endfunction

  function automatic int unsigned hdr_marker_bit(input int unsigned word_bits);
    return word_bits - 2;
  endfunction

  function automatic int unsigned hdr_mem_bit(input int unsigned word_bits);
    return word_bits - 3;
  endfunction

endpackage

// File: rtl/uart_word_rx.sv
// UART word receiver: 2-flop synchroniser, start bit re-checked at half-bit,
// data sampled mid-bit LSB first, one stop bit. Pulses word_valid or frame_err.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORD_BITS    = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(WORD_BITS + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(WORD_BITS - 1);

  // RxWait holds off after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  rx_state_e             st_q, st_d;
  logic                  meta_q, sync_q;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  // Bit-timing state machine next-state logic.
  always_comb begin
    st_d      = st_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (st_q)
      RxIdle: begin
        if (!sync_q) begin
          st_d      = RxStart;
          clk_cnt_d = '0;
        end
      end
      RxStart: begin
        if (clk_cnt_q == HalfCnt) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          st_d      = sync_q ? RxIdle : RxData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (clk_cnt_q == LastCnt) begin
          clk_cnt_d = '0;
          shift_d   = {sync_q, shift_q[WORD_BITS-1:1]};
          if (bit_cnt_q == LastBit) st_d = RxStop;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (clk_cnt_q == LastCnt) begin
          clk_cnt_d = '0;
          if (sync_q) begin
            valid_d = 1'b1;
            st_d    = RxIdle;
          end else begin
            ferr_d = 1'b1;
            st_d   = RxWait;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RxWait: begin
        if (sync_q) st_d = RxIdle;
      end
      default: st_d = RxIdle;
    endcase
  end

  // Synchroniser and receiver state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      st_q      <= RxIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      meta_q    <= rx;
      sync_q    <= meta_q;
      st_q      <= st_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign word       = shift_q;
  assign word_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_packet_rx.sv
// UART packet receiver: header word plus PAYLOAD_BYTES payload words, presented
// on a valid/ready interface with timeout, framing, header and overrun errors.
// Optional trailing XOR checksum word when UART_PKT_CHECKSUM_EN is defined.
module uart_packet_rx
  import uart_pkt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned WORD_BITS     = 12,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned ADDR_BITS     = 9,
  parameter int unsigned TIMEOUT_CLKS  = 16 * CLKS_PER_BIT * WORD_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  output logic [PAYLOAD_BYTES*8-1:0] pkt_data,
  output logic [ADDR_BITS-1:0]       pkt_addr,
  output logic                       pkt_mem_type,
  output logic                       pkt_rw,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic                       busy
);

  localparam int unsigned RwBit     = hdr_rw_bit(WORD_BITS);
  localparam int unsigned MarkerBit = hdr_marker_bit(WORD_BITS);
  localparam int unsigned MemBit    = hdr_mem_bit(WORD_BITS);
  localparam int unsigned CntW      = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned TmoW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_BYTES - 1);
  localparam logic [TmoW-1:0] LastTmo = TmoW'(TIMEOUT_CLKS - 1);

  logic [WORD_BITS-1:0] word;
  logic                 word_valid;
  logic                 frame_err;

  uart_word_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .WORD_BITS   (WORD_BITS)
  ) u_word_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .word      (word),
    .word_valid(word_valid),
    .frame_err (frame_err)
  );

  logic unused_word;
  assign unused_word = ^word;

  pkt_state_e                 state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [TmoW-1:0]            tmo_q, tmo_d;
  logic [PAYLOAD_BYTES*8-1:0] data_q, data_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic                       mem_q, mem_d;
  logic                       rw_q, rw_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic [2:0]                 code_q, code_d;
  logic [7:0]                 csum_q, csum_d;
  int unsigned                lane;

  // Packet FSM next-state, byte assembly, timeout and error reporting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    data_d  = data_q;
    addr_d  = addr_q;
    mem_d   = mem_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    code_d  = code_q;
    csum_d  = csum_q;
    lane    = PAYLOAD_BYTES - 1 - 32'(cnt_q);
    case (state_q)
      StIdle: begin
        if (frame_err) begin
          err_d  = 1'b1;
          code_d = ERR_FRAME;
        end else if (word_valid) begin
          if (!word[MarkerBit]) begin
            err_d  = 1'b1;
            code_d = ERR_HDR;
          end else begin
            addr_d = word[ADDR_BITS-1:0];
            mem_d  = word[MemBit];
            rw_d   = word[RwBit];
            csum_d = word[7:0];
            if (word[RwBit]) begin
              cnt_d   = '0;
              state_d = StPayload;
            end else begin
              data_d = '0;
`ifdef UART_PKT_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StHold;
              valid_d = 1'b1;
`endif
            end
          end
        end
      end
      StPayload: begin
        if (frame_err) begin
          err_d   = 1'b1;
          code_d  = ERR_FRAME;
          state_d = StIdle;
        end else if (word_valid) begin
          data_d[lane*8 +: 8] = word[7:0];
          csum_d = csum_q ^ word[7:0];
          if (cnt_q == LastCnt) begin
`ifdef UART_PKT_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StHold;
            valid_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == LastTmo) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef UART_PKT_CHECKSUM_EN
      StCheck: begin
        if (frame_err) begin
          err_d   = 1'b1;
          code_d  = ERR_FRAME;
          state_d = StIdle;
        end else if (word_valid) begin
          if (word[7:0] == csum_q) begin
            state_d = StHold;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = StIdle;
          end
        end else if (tmo_q == LastTmo) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      StHold: begin
        // Outputs are frozen here; stray words are dropped and flagged.
        if (frame_err) begin
          err_d  = 1'b1;
          code_d = ERR_FRAME;
        end else if (word_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (valid_q && pkt_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Packet FSM registers; reset discards any partial packet silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      mem_q   <= 1'b0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      mem_q   <= mem_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      csum_q  <= csum_d;
    end
  end

  assign pkt_data     = data_q;
  assign pkt_addr     = addr_q;
  assign pkt_mem_type = mem_q;
  assign pkt_rw       = rw_q;
  assign pkt_valid    = valid_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx with CLKS_PER_BIT=4, WORD_BITS=12,
// PAYLOAD_BYTES=4, ADDR_BITS=9. Honours UART_PKT_CHECKSUM_EN when defined.
module tb_uart_packet_rx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Tmo = 16 * 4 * 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        pkt_ready = 1'b1;
  logic [31:0] pkt_data;
  logic [8:0]  pkt_addr;
  logic        pkt_mem_type, pkt_rw, pkt_valid, err, busy;
  logic [2:0]  err_code;

  int n_vec = 0;
  int n_fail = 0;

  // Event monitor: counts err pulses and accepted packets.
  int          err_seen = 0;
  int          acc_seen = 0;
  logic [2:0]  code_seen = '0;
  logic [31:0] cap_data = '0;
  logic [8:0]  cap_addr = '0;
  logic        cap_mem = 1'b0;
  logic        cap_rw = 1'b0;

  uart_packet_rx #(
    .CLKS_PER_BIT (Cpb),
    .WORD_BITS    (12),
    .PAYLOAD_BYTES(4),
    .ADDR_BITS    (9),
    .TIMEOUT_CLKS (Tmo)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .pkt_data    (pkt_data),
    .pkt_addr    (pkt_addr),
    .pkt_mem_type(pkt_mem_type),
    .pkt_rw      (pkt_rw),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) begin
      err_seen  <= err_seen + 1;
      code_seen <= err_code;
    end
    if (pkt_valid && pkt_ready) begin
      acc_seen <= acc_seen + 1;
      cap_data <= pkt_data;
      cap_addr <= pkt_addr;
      cap_mem  <= pkt_mem_type;
      cap_rw   <= pkt_rw;
    end
  end

  task automatic send_word(input logic [11:0] w, input logic stop);
    rx = 1'b0;
    repeat (Cpb) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      rx = w[i];
      repeat (Cpb) @(posedge clk);
    end
    rx = stop;
    repeat (Cpb) @(posedge clk);
    rx = 1'b1;
    repeat (Cpb) @(posedge clk);
  endtask

  // Header, nbytes payload bytes (MSB first) and, if enabled, the XOR checksum.
  task automatic send_packet(input logic [11:0] hdr, input logic [31:0] data, input int nbytes);
    logic [7:0] cs;
    logic [7:0] b;
    cs = hdr[7:0];
    send_word(hdr, 1'b1);
    for (int i = 0; i < nbytes; i++) begin
      b  = data[31-8*i -: 8];
      cs = cs ^ b;
      send_word({4'h0, b}, 1'b1);
    end
`ifdef UART_PKT_CHECKSUM_EN
    send_word({4'h0, cs}, 1'b1);
`endif
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if ({pkt_valid, err, busy, err_code, pkt_data, pkt_addr, pkt_mem_type, pkt_rw} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b err=%b busy=%b code=%0d data=%h addr=%h",
               pkt_valid, err, busy, err_code, pkt_data, pkt_addr);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write();
    int e0, a0;
    e0 = err_seen; a0 = acc_seen;
    pkt_ready = 1'b1;
    send_packet(12'hE05, 32'hDEADBEEF, 4);
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (acc_seen - a0 !== 1) begin
      n_fail++; $display("FAIL write_valid_cycles: got %0d want 1", acc_seen - a0);
    end
    n_vec++;
    if (cap_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_data: got %h want deadbeef", cap_data);
    end
    n_vec++;
    if ({cap_addr, cap_mem, cap_rw} !== {9'h005, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL write_hdr: got addr=%h mem=%b rw=%b want 005 1 1",
                         cap_addr, cap_mem, cap_rw);
    end
    n_vec++;
    if (err_seen - e0 !== 0 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_idle: got errs=%0d busy=%b valid=%b want 0 0 0",
                         err_seen - e0, busy, pkt_valid);
    end
  endtask

  task automatic test_read();
    int a0;
    a0 = acc_seen;
    send_packet(12'h67F, 32'h0, 0);
    repeat (10) @(posedge clk);
    n_vec++;
    if (acc_seen - a0 !== 1) begin
      n_fail++; $display("FAIL read_valid: got %0d packets want 1", acc_seen - a0);
    end
    n_vec++;
    if ({cap_data, cap_addr, cap_mem, cap_rw} !== {32'h0, 9'h07F, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL read_pkt: got data=%h addr=%h mem=%b rw=%b want 0 07f 1 0",
                         cap_data, cap_addr, cap_mem, cap_rw);
    end
  endtask

  task automatic test_bad_header();
    int e0, a0;
    e0 = err_seen; a0 = acc_seen;
    send_word(12'h805, 1'b1);
    repeat (4) @(posedge clk);
    n_vec++;
    if (err_seen - e0 !== 1 || code_seen !== 3'd0) begin
      n_fail++; $display("FAIL bad_header_err: got %0d errs code %0d want 1 code 0",
                         err_seen - e0, code_seen);
    end
    send_packet(12'hE12, 32'h11223344, 4);
    repeat (10) @(posedge clk);
    n_vec++;
    if (acc_seen - a0 !== 1 || cap_data !== 32'h11223344 || cap_addr !== 9'h012) begin
      n_fail++; $display("FAIL bad_header_recover: got %0d pkts data=%h addr=%h want 1 11223344 012",
                         acc_seen - a0, cap_data, cap_addr);
    end
  endtask

  task automatic test_timeout();
    int e0, a0;
    e0 = err_seen; a0 = acc_seen;
    send_word(12'hE05, 1'b1);
    send_word(12'h0DE, 1'b1);
    send_word(12'h0AD, 1'b1);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_busy_mid: got %b want 1", busy);
    end
    repeat (Tmo + 10) @(posedge clk);
    #1;
    n_vec++;
    if (err_seen - e0 !== 1 || code_seen !== 3'd2) begin
      n_fail++; $display("FAIL timeout_err: got %0d errs code %0d want 1 code 2",
                         err_seen - e0, code_seen);
    end
    n_vec++;
    if (acc_seen - a0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_state: got pkts=%0d busy=%b want 0 0", acc_seen - a0, busy);
    end
  endtask

  task automatic test_back_pressure();
    int e0, a0;
    pkt_ready = 1'b0;
    send_packet(12'hE05, 32'hDEADBEEF, 4);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (pkt_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b busy=%b want 1 1", pkt_valid, busy);
    end
    e0 = err_seen; a0 = acc_seen;
    send_word(12'hE01, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (err_seen - e0 !== 1 || code_seen !== 3'd3) begin
      n_fail++; $display("FAIL bp_overrun: got %0d errs code %0d want 1 code 3",
                         err_seen - e0, code_seen);
    end
    n_vec++;
    if (pkt_valid !== 1'b1 || pkt_data !== 32'hDEADBEEF || pkt_addr !== 9'h005) begin
      n_fail++; $display("FAIL bp_stable: got valid=%b data=%h addr=%h want 1 deadbeef 005",
                         pkt_valid, pkt_data, pkt_addr);
    end
    @(negedge clk);
    pkt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || acc_seen - a0 !== 1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b busy=%b accepted=%0d want 0 0 1",
                         pkt_valid, busy, acc_seen - a0);
    end
  endtask

  task automatic test_framing();
    int e0, a0;
    e0 = err_seen; a0 = acc_seen;
    send_word(12'hE05, 1'b1);
    send_word(12'h0DE, 1'b1);
    send_word(12'h0AD, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (err_seen - e0 !== 1 || code_seen !== 3'd1) begin
      n_fail++; $display("FAIL framing_err: got %0d errs code %0d want 1 code 1",
                         err_seen - e0, code_seen);
    end
    n_vec++;
    if (busy !== 1'b0 || acc_seen - a0 !== 0) begin
      n_fail++; $display("FAIL framing_idle: got busy=%b pkts=%0d want 0 0", busy, acc_seen - a0);
    end
  endtask

  task automatic test_reset_mid_packet();
    int e0, a0;
    e0 = err_seen;
    send_word(12'hE05, 1'b1);
    send_word(12'h0DE, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({pkt_valid, err, busy, err_code, pkt_data, pkt_addr, pkt_mem_type, pkt_rw} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b err=%b busy=%b code=%0d data=%h addr=%h",
               pkt_valid, err, busy, err_code, pkt_data, pkt_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    n_vec++;
    if (err_seen - e0 !== 0) begin
      n_fail++; $display("FAIL reset_no_err: got %0d errs want 0", err_seen - e0);
    end
    a0 = acc_seen;
    send_packet(12'h67F, 32'h0, 0);
    repeat (10) @(posedge clk);
    n_vec++;
    if (acc_seen - a0 !== 1 || cap_addr !== 9'h07F) begin
      n_fail++; $display("FAIL reset_recover: got %0d pkts addr=%h want 1 07f",
                         acc_seen - a0, cap_addr);
    end
  endtask

`ifdef UART_PKT_CHECKSUM_EN
  task automatic test_checksum();
    int e0, a0;
    e0 = err_seen; a0 = acc_seen;
    send_word(12'hE05, 1'b1);
    send_word(12'h0DE, 1'b1);
    send_word(12'h0AD, 1'b1);
    send_word(12'h0BE, 1'b1);
    send_word(12'h0EF, 1'b1);
    send_word(12'h028, 1'b1);  // correct value is 0x27
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (err_seen - e0 !== 1 || code_seen !== 3'd4 || acc_seen - a0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL csum_err: got errs=%0d code=%0d pkts=%0d busy=%b want 1 4 0 0",
                         err_seen - e0, code_seen, acc_seen - a0, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_header();
    test_timeout();
    test_back_pressure();
    test_framing();
    test_reset_mid_packet();
`ifdef UART_PKT_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
